// File: rtl/sqrt_pkg.sv
// sqrt_pkg
// Shared widths and state encoding for the square-root datapath stages.
//   LOW_W  : width of the low partial sum
//   HIGH_W : width of each high operand slice
//   SUM_W  : width of the assembled sum, square and result registers
//   CNT_W  : width of the iteration counter
package sqrt_pkg;

  localparam int LOW_W  = 8;
  localparam int HIGH_W = 9;
  localparam int SUM_W  = 17;
  localparam int CNT_W  = 4;

  // Full assembled width: carry-extended high part above the low part.
  localparam int FULL_W = HIGH_W + 1 + LOW_W;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/stage3_hadd.sv
// stage3_hadd
// High-part adder: sum = a + b + cin, one bit wider than the operands so
// that the carry out is kept.
// Ports:
//   a, b : HIGH_W-bit operand slices
//   cin  : carry in from the low partial sum
//   sum  : (HIGH_W+1)-bit result
module stage3_hadd
  import sqrt_pkg::*;
(
  input  logic [HIGH_W-1:0] a,
  input  logic [HIGH_W-1:0] b,
  input  logic              cin,
  output logic [HIGH_W:0]   sum
);

  // Zero-extend everything to the result width so the carry lands in the MSB.
  assign sum = {1'b0, a} + {1'b0, b} + {{HIGH_W{1'b0}}, cin};

endmodule

// File: rtl/stage3.sv
// stage3
// Final stage of the iterative square-root pipeline. Assembles the full sum
// from the high operand slices and the low partial sum, registers it for the
// upstream feedback path, optionally loads the square register, and captures
// the final result when the last operand set arrives. While the result is
// pending (DONE) the stage stalls upstream until the consumer acknowledges.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   en_pipe_i             : pipeline advance (qualifies all inputs but ack_i)
//   ready_i               : final-iteration operand set
//   wr_square_s_i         : load square register this iteration
//   N_i                   : iteration sign flag, passed through registered
//   sum_low_i, Co_i       : low partial sum and its carry out
//   A_high_i, B_high_i    : high operand slices
//   ack_i                 : consumer accepts the result
//   sum_o, sign_o, N_o    : registered assembled sum, its bit 17, registered N_i
//   square_o, result_o    : square register, captured final result
//   done_o, stall_o       : result valid / hold upstream (decoded from state)
//   iter_cnt_o            : advances since the last done, saturating
//   ovf_o                 : sticky overflow flag
//
// Build option: define STAGE3_OVF_EN to implement the sticky overflow flag;
// otherwise ovf_o is tied to 0.
module stage3
  import sqrt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_pipe_i,
  input  logic              ready_i,
  input  logic              wr_square_s_i,
  input  logic              N_i,
  input  logic [LOW_W-1:0]  sum_low_i,
  input  logic              Co_i,
  input  logic [HIGH_W-1:0] A_high_i,
  input  logic [HIGH_W-1:0] B_high_i,
  input  logic              ack_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic              sign_o,
  output logic              N_o,
  output logic [SUM_W-1:0]  square_o,
  output logic [SUM_W-1:0]  result_o,
  output logic              done_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  iter_cnt_o,
  output logic              ovf_o
);

  state_t state;
  state_t state_next;

  logic [HIGH_W:0]    high;
  logic [FULL_W-1:0]  full;
  logic               accept;
  logic               capture;
  logic [SUM_W-1:0]   square_next;

  stage3_hadd u_hadd (
    .a   (A_high_i),
    .b   (B_high_i),
    .cin (Co_i),
    .sum (high)
  );

  assign full = {high, sum_low_i};

  // Advances only count in IDLE; in DONE the stage is frozen.
  assign accept  = en_pipe_i && (state == IDLE);
  assign capture = accept && ready_i;

  // Value the square register holds after this edge, so a same-cycle square
  // write is reflected in the captured result.
  assign square_next = (accept && wr_square_s_i) ? full[SUM_W-1:0] : square_o;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: capture moves to DONE, ack releases back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (capture) state_next = DONE;
      DONE: if (ack_i)   state_next = IDLE;
      default:           state_next = IDLE;
    endcase
  end

  assign done_o  = (state == DONE);
  assign stall_o = (state == DONE);

  // Datapath registers: feedback sum, sign, N, square and captured result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_o    <= '0;
      sign_o   <= 1'b0;
      N_o      <= 1'b0;
      square_o <= '0;
      result_o <= '0;
    end else if (accept) begin
      sum_o    <= full[SUM_W-1:0];
      sign_o   <= full[SUM_W];
      N_o      <= N_i;
      square_o <= square_next;
      if (ready_i) begin
        result_o <= square_next;
      end
    end
  end

  // Iteration counter: saturating count of advances, cleared by the capture
  // advance itself so DONE always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter_cnt_o <= '0;
    end else if (accept) begin
      if (ready_i) begin
        iter_cnt_o <= '0;
      end else if (iter_cnt_o != CNT_MAX) begin
        iter_cnt_o <= iter_cnt_o + CNT_W'(1);
      end
    end
  end

`ifdef STAGE3_OVF_EN
  logic ovf_q;

  // Sticky overflow: a square write whose full sum spills into bit 17.
  // Cleared when the consumer releases the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == DONE && ack_i) begin
      ovf_q <= 1'b0;
    end else if (accept && wr_square_s_i && full[SUM_W]) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_stage3.sv
// tb_stage3
// Directed self-checking bench for stage3. Inputs are driven just after a
// rising edge and outputs are sampled 1 time unit after the next rising edge.
module tb_stage3;
  import sqrt_pkg::*;

`ifdef STAGE3_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              en_pipe_i;
  logic              ready_i;
  logic              wr_square_s_i;
  logic              N_i;
  logic [LOW_W-1:0]  sum_low_i;
  logic              Co_i;
  logic [HIGH_W-1:0] A_high_i;
  logic [HIGH_W-1:0] B_high_i;
  logic              ack_i;
  logic [SUM_W-1:0]  sum_o;
  logic              sign_o;
  logic              N_o;
  logic [SUM_W-1:0]  square_o;
  logic [SUM_W-1:0]  result_o;
  logic              done_o;
  logic              stall_o;
  logic [CNT_W-1:0]  iter_cnt_o;
  logic              ovf_o;

  int checks = 0;
  int errors = 0;

  stage3 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_pipe_i     (en_pipe_i),
    .ready_i       (ready_i),
    .wr_square_s_i (wr_square_s_i),
    .N_i           (N_i),
    .sum_low_i     (sum_low_i),
    .Co_i          (Co_i),
    .A_high_i      (A_high_i),
    .B_high_i      (B_high_i),
    .ack_i         (ack_i),
    .sum_o         (sum_o),
    .sign_o        (sign_o),
    .N_o           (N_o),
    .square_o      (square_o),
    .result_o      (result_o),
    .done_o        (done_o),
    .stall_o       (stall_o),
    .iter_cnt_o    (iter_cnt_o),
    .ovf_o         (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of operand inputs, then advance one clock edge.
  task automatic applyStimulus(input logic en, input logic rdy, input logic wr,
                               input logic n, input logic [HIGH_W-1:0] a,
                               input logic [HIGH_W-1:0] b, input logic co,
                               input logic [LOW_W-1:0] low, input logic ack);
    en_pipe_i     = en;
    ready_i       = rdy;
    wr_square_s_i = wr;
    N_i           = n;
    A_high_i      = a;
    B_high_i      = b;
    Co_i          = co;
    sum_low_i     = low;
    ack_i         = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [SUM_W-1:0] obs,
                             input logic [SUM_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%05h expected=0x%05h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);

    // Reset with the pipeline enabled and random operands.
    applyStimulus(1'b1, 1'($urandom), 1'b1, 1'($urandom), HIGH_W'($urandom),
                  HIGH_W'($urandom), 1'($urandom), LOW_W'($urandom), 1'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9'h1FF, 9'h1FF, 1'b1, 8'hFF, 1'b0);
    checkOutput("rst_sum",    sum_o, 17'h0);
    checkOutput("rst_sign",   17'(sign_o), 17'h0);
    checkOutput("rst_N",      17'(N_o), 17'h0);
    checkOutput("rst_square", square_o, 17'h0);
    checkOutput("rst_result", result_o, 17'h0);
    checkOutput("rst_done",   17'(done_o), 17'h0);
    checkOutput("rst_stall",  17'(stall_o), 17'h0);
    checkOutput("rst_cnt",    17'(iter_cnt_o), 17'h0);
    checkOutput("rst_ovf",    17'(ovf_o), 17'h0);

    rst_n = 1'b1;
    $display("[TB] assembly");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'h0FF, 9'h001, 1'b1, 8'hAB, 1'b0);
    checkOutput("asm_sum",    sum_o, 17'h101AB);
    checkOutput("asm_sign",   17'(sign_o), 17'h0);
    checkOutput("asm_N",      17'(N_o), 17'h1);
    checkOutput("asm_square", square_o, 17'h0);
    checkOutput("asm_cnt",    17'(iter_cnt_o), 17'h1);

    $display("[TB] square write with overflow");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'h1FF, 9'h1FF, 1'b1, 8'h00, 1'b0);
    checkOutput("sq_square", square_o, 17'h1FF00);
    checkOutput("sq_sum",    sum_o, 17'h1FF00);
    checkOutput("sq_sign",   17'(sign_o), 17'h1);
    checkOutput("sq_N",      17'(N_o), 17'h0);
    checkOutput("sq_ovf",    17'(ovf_o), 17'(OVF_ON));
    checkOutput("sq_cnt",    17'(iter_cnt_o), 17'h2);

    $display("[TB] hold with en_pipe_i low");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 9'h003, 9'h004, 1'b0, 8'h55, 1'b1);
    checkOutput("hold_sum",    sum_o, 17'h1FF00);
    checkOutput("hold_square", square_o, 17'h1FF00);
    checkOutput("hold_cnt",    17'(iter_cnt_o), 17'h2);
    checkOutput("hold_done",   17'(done_o), 17'h0);

    // Fresh start for the completion sequence.
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("rst2_square", square_o, 17'h0);
    checkOutput("rst2_ovf",    17'(ovf_o), 17'h0);
    rst_n = 1'b1;

    $display("[TB] completion");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, HIGH_W'(i), 9'h000, 1'b0, LOW_W'(i), 1'b0);
    end
    checkOutput("cmp_cnt4", 17'(iter_cnt_o), 17'h4);
    checkOutput("cmp_sum4", sum_o, 17'h00404);
    // 0x012 + 0x034 + 1 = 0x047 -> full 0x04756
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'h012, 9'h034, 1'b1, 8'h56, 1'b0);
    checkOutput("cmp_done",   17'(done_o), 17'h1);
    checkOutput("cmp_stall",  17'(stall_o), 17'h1);
    checkOutput("cmp_result", result_o, 17'h04756);
    checkOutput("cmp_square", square_o, 17'h04756);
    checkOutput("cmp_cnt",    17'(iter_cnt_o), 17'h0);

    $display("[TB] hold in DONE");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9'h100, 9'h100, 1'b0, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9'h1FF, 9'h1FF, 1'b1, 8'h11, 1'b0);
    checkOutput("dh_sum",    sum_o, 17'h04756);
    checkOutput("dh_sign",   17'(sign_o), 17'h0);
    checkOutput("dh_N",      17'(N_o), 17'h0);
    checkOutput("dh_square", square_o, 17'h04756);
    checkOutput("dh_result", result_o, 17'h04756);
    checkOutput("dh_cnt",    17'(iter_cnt_o), 17'h0);
    checkOutput("dh_done",   17'(done_o), 17'h1);
    checkOutput("dh_ovf",    17'(ovf_o), 17'h0);

    // ack releases DONE; ready/en in this same cycle is ignored.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'h001, 9'h001, 1'b0, 8'h01, 1'b1);
    checkOutput("ack_done",   17'(done_o), 17'h0);
    checkOutput("ack_stall",  17'(stall_o), 17'h0);
    checkOutput("ack_result", result_o, 17'h04756);
    checkOutput("ack_sum",    sum_o, 17'h04756);

    // ack while IDLE has no effect.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput("idle_ack_done", 17'(done_o), 17'h0);

    $display("[TB] capture after release, with overflow");
    // 0x1FF + 0x1FF + 1 = 0x3FF -> full 0x3FF22, bit 17 set
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9'h1FF, 9'h1FF, 1'b1, 8'h22, 1'b0);
    checkOutput("cap2_done",   17'(done_o), 17'h1);
    checkOutput("cap2_result", result_o, 17'h1FF22);
    checkOutput("cap2_sign",   17'(sign_o), 17'h1);
    checkOutput("cap2_ovf",    17'(ovf_o), 17'(OVF_ON));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput("cap2_ack_done", 17'(done_o), 17'h0);
    checkOutput("cap2_ack_ovf",  17'(ovf_o), 17'h0);

    // Capture without a square write takes the held square value.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 9'h001, 9'h002, 1'b0, 8'h33, 1'b0);
    checkOutput("cap3_result", result_o, 17'h1FF22);
    checkOutput("cap3_sum",    sum_o, 17'h00333);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

    $display("[TB] saturation and mid-run reset");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, HIGH_W'(i), 9'h000, 1'b0, 8'h00, 1'b0);
    end
    checkOutput("sat_cnt15", 17'(iter_cnt_o), 17'hF);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 9'h020, 9'h000, 1'b0, 8'h00, 1'b0);
    end
    checkOutput("sat_cnt20", 17'(iter_cnt_o), 17'hF);
    checkOutput("sat_sum",   sum_o, 17'h02000);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 9'h055, 9'h055, 1'b1, 8'h77, 1'b1);
    checkOutput("midrst_cnt",    17'(iter_cnt_o), 17'h0);
    checkOutput("midrst_done",   17'(done_o), 17'h0);
    checkOutput("midrst_sum",    sum_o, 17'h0);
    checkOutput("midrst_result", result_o, 17'h0);

    // Reset also wins while in DONE.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 9'h001, 9'h001, 1'b0, 8'h01, 1'b0);
    checkOutput("pre_rst_done", 17'(done_o), 17'h1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("done_rst_done",   17'(done_o), 17'h0);
    checkOutput("done_rst_square", square_o, 17'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
